// File: rtl/core_run_ctrl_if.sv
// Core-side bundle for core_run_ctrl: core observation inputs plus run control/status outputs.
// master = run controller, slave = core (or bench) side.
interface core_run_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic [XLEN-1:0]  pc;
   logic             retire;
   logic             mem_we;
   logic [XLEN-1:0]  mem_addr;
   logic [XLEN-1:0]  mem_wdata;
   logic             core_rst_n;
   logic             core_en;
   logic [2:0]       state;
   logic             done;
   logic             pass;
   logic [XLEN-2:0]  exit_code;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instret;

   modport master (
      input  pc, retire, mem_we, mem_addr, mem_wdata,
      output core_rst_n, core_en, state, done, pass, exit_code, cycle_count, instret
   );

   modport slave (
      output pc, retire, mem_we, mem_addr, mem_wdata,
      input  core_rst_n, core_en, state, done, pass, exit_code, cycle_count, instret
   );
endinterface

// File: rtl/core_run_ctrl.sv
// Run controller: sequences core reset, counts RUN cycles/retires, ends on tohost store, PC halt or timeout.
// Latency: all outputs registered, terminal state one edge after the deciding cycle; no backpressure.
// CORE_RUN_CTRL_FREEZE_EN: when defined, core_en drops on entry to any terminal state.
module core_run_ctrl #(
   parameter int              XLEN         = 32,
   parameter int              CNT_W        = 32,
   parameter int              RESET_CYCLES = 3,
   parameter int              MAX_CYCLES   = 1000,
   parameter int              HALT_REPEAT  = 4,
   parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            rst,
   core_run_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      ST_HOLD    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_HALT    = 3'd4,
      ST_TIMEOUT = 3'd5
   } state_e;

   // RESET_CYCLES of 0 behaves as 1
   localparam logic [31:0]      HOLD_LAST = (RESET_CYCLES <= 1) ? 32'd0 : 32'(RESET_CYCLES - 1);
   localparam logic [31:0]      HALT_LAST = (HALT_REPEAT <= 1) ? 32'd0 : 32'(HALT_REPEAT - 1);
   localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
   localparam logic [XLEN-1:0]  DATA_ONE  = XLEN'(1);

   state_e           state_q, state_d;
   logic [31:0]      hold_cnt_q, hold_cnt_d;
   logic [31:0]      halt_cnt_q, halt_cnt_d;
   logic [XLEN-1:0]  pc_prev_q, pc_prev_d;
   logic             core_rst_n_q, core_rst_n_d;
   logic             core_en_q, core_en_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [XLEN-2:0]  exit_code_q, exit_code_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic pc_eq;
   logic tohost;
   logic term;

   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      halt_cnt_d    = halt_cnt_q;
      pc_prev_d     = pc_prev_q;
      core_rst_n_d  = core_rst_n_q;
      core_en_d     = core_en_q;
      done_d        = done_q;
      pass_d        = pass_q;
      exit_code_d   = exit_code_q;
      cycle_count_d = cycle_count_q;
      instret_d     = instret_q;
      pc_eq         = (bus.pc == pc_prev_q);
      tohost        = bus.mem_we && (bus.mem_addr == TOHOST_ADDR);
      term          = 1'b0;

      case (state_q)
         ST_HOLD: begin
            hold_cnt_d = hold_cnt_q + 32'd1;
            if (hold_cnt_q == HOLD_LAST) begin
               state_d      = ST_RUN;
               core_rst_n_d = 1'b1;
               core_en_d    = 1'b1;
            end
         end
         ST_RUN: begin
            pc_prev_d     = bus.pc;
            halt_cnt_d    = pc_eq ? (halt_cnt_q + 32'd1) : 32'd0;
            cycle_count_d = (&cycle_count_q) ? cycle_count_q : (cycle_count_q + 1'b1);
            if (bus.retire && !(&instret_q))
               instret_d = instret_q + 1'b1;
            term = 1'b1;
            // Priority: tohost pass, tohost fail, PC halt, timeout
            if (tohost && (bus.mem_wdata == DATA_ONE)) begin
               state_d = ST_PASS;
               pass_d  = 1'b1;
            end else if (tohost) begin
               state_d     = ST_FAIL;
               exit_code_d = bus.mem_wdata[XLEN-1:1];
            end else if (pc_eq && (halt_cnt_q == HALT_LAST)) begin
               state_d = ST_HALT;
            end else if (cycle_count_q == CYC_LAST) begin
               state_d = ST_TIMEOUT;
            end else begin
               term = 1'b0;
            end
            if (term) begin
               done_d = 1'b1;
`ifdef CORE_RUN_CTRL_FREEZE_EN
               core_en_d = 1'b0;
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_HOLD;
         hold_cnt_q    <= '0;
         halt_cnt_q    <= '0;
         pc_prev_q     <= '0;
         core_rst_n_q  <= 1'b0;
         core_en_q     <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         exit_code_q   <= '0;
         cycle_count_q <= '0;
         instret_q     <= '0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         halt_cnt_q    <= halt_cnt_d;
         pc_prev_q     <= pc_prev_d;
         core_rst_n_q  <= core_rst_n_d;
         core_en_q     <= core_en_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         exit_code_q   <= exit_code_d;
         cycle_count_q <= cycle_count_d;
         instret_q     <= instret_d;
      end
   end

   assign bus.state       = state_q;
   assign bus.core_rst_n  = core_rst_n_q;
   assign bus.core_en     = core_en_q;
   assign bus.done        = done_q;
   assign bus.pass        = pass_q;
   assign bus.exit_code   = exit_code_q;
   assign bus.cycle_count = cycle_count_q;
   assign bus.instret     = instret_q;
endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed runs; expectations queued at stimulus time, checked by a negedge monitor.
module tb_core_run_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

`ifdef CORE_RUN_CTRL_FREEZE_EN
   localparam logic TERM_EN = 1'b0;
`else
   localparam logic TERM_EN = 1'b1;
`endif

   typedef struct {
      int          at;
      string       name;
      logic [2:0]  st;
      logic        rn;
      logic        en;
      logic        dn;
      logic        ps;
      logic [30:0] ec;
      logic [31:0] cc;
      logic [31:0] ir;
   } exp_t;

   exp_t snap_q[$];
   exp_t done_q[$];
   logic done_seen = 1'b0;

   core_run_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();

   core_run_ctrl #(.MAX_CYCLES(50)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   function automatic exp_t mk(input int at, input string n, input logic [2:0] st,
                               input logic rn, input logic en, input logic dn, input logic ps,
                               input logic [30:0] ec, input logic [31:0] cc, input logic [31:0] ir);
      exp_t e;
      e.at = at; e.name = n; e.st = st; e.rn = rn; e.en = en;
      e.dn = dn; e.ps = ps; e.ec = ec; e.cc = cc; e.ir = ir;
      return e;
   endfunction

   function automatic exp_t term(input string n, input logic [2:0] st, input logic [30:0] ec,
                                 input logic [31:0] cc, input logic [31:0] ir);
      return mk(0, n, st, 1'b1, TERM_EN, 1'b1, (st == 3'd2), ec, cc, ir);
   endfunction

   task automatic cmp(input exp_t e);
      chk({e.name, ".state"},      64'(bus.state),       64'(e.st));
      chk({e.name, ".core_rst_n"}, 64'(bus.core_rst_n),  64'(e.rn));
      chk({e.name, ".core_en"},    64'(bus.core_en),     64'(e.en));
      chk({e.name, ".done"},       64'(bus.done),        64'(e.dn));
      chk({e.name, ".pass"},       64'(bus.pass),        64'(e.ps));
      chk({e.name, ".exit_code"},  64'(bus.exit_code),   64'(e.ec));
      chk({e.name, ".cycle_count"},64'(bus.cycle_count), 64'(e.cc));
      chk({e.name, ".instret"},    64'(bus.instret),     64'(e.ir));
   endtask

   // Monitor: snapshot entries fire at their cycle stamp, terminal entries fire on done rising
   always @(negedge clk) begin
      while (snap_q.size() != 0 && snap_q[0].at < cyc) begin
         exp_t m;
         m = snap_q.pop_front();
         chk({m.name, ".missed"}, 64'(cyc), 64'(m.at));
      end
      if (snap_q.size() != 0 && snap_q[0].at == cyc) cmp(snap_q.pop_front());
      if (bus.done && !done_seen) begin
         if (done_q.size() != 0) cmp(done_q.pop_front());
         else chk("unexpected_done", 64'(bus.state), 64'd1);
      end
      done_seen = bus.done;
   end

   task automatic step(input logic [31:0] p, input logic r, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
      bus.pc = p; bus.retire = r; bus.mem_we = we; bus.mem_addr = a; bus.mem_wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      int c;
      bus.pc = '0; bus.retire = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      c = cyc;
      snap_q.push_back(mk(c + 1, "rel_edge1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0));
      snap_q.push_back(mk(c + 2, "rel_edge2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0));
      snap_q.push_back(mk(c + 3, "rel_edge3", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0));
   endtask

   // After this returns, the next step() drives RUN cycle 1
   task automatic start_run();
      do_reset();
      repeat (3) step('0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic sticky(input exp_t e);
      exp_t s;
      s = e;
      s.at = cyc;
      snap_q.push_back(s);
   endtask

   task automatic drained(input string n);
      repeat (3) @(negedge clk);
      chk({n, ".pending"}, 64'(done_q.size() + snap_q.size()), 64'd0);
      done_q.delete();
      snap_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.pc = '0; bus.retire = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
      #2;

      // PASS at RUN cycle 20, retiring every cycle; later stores ignored
      start_run();
      done_q.push_back(term("pass", 3'd2, '0, 32'd20, 32'd20));
      for (int k = 1; k <= 19; k++) step(32'(4 * k), 1'b1, 1'b0, '0, '0);
      step(32'h50, 1'b1, 1'b1, 32'h100, 32'd1);
      step(32'h54, 1'b1, 1'b1, 32'h100, 32'd7);
      sticky(term("pass_sticky", 3'd2, '0, 32'd20, 32'd20));
      step(32'h58, 1'b1, 1'b0, '0, '0);
      drained("pass");

      // FAIL with data 7 at cycle 5; odd-cycle retires; non-tohost store ignored
      start_run();
      done_q.push_back(term("fail", 3'd3, 31'd3, 32'd5, 32'd3));
      for (int k = 1; k <= 4; k++)
         step(32'(4 * k), (k % 2) == 1, (k == 2), 32'h104, 32'd1);
      step(32'h14, 1'b1, 1'b1, 32'h100, 32'd7);
      step(32'h18, 1'b1, 1'b1, 32'h100, 32'd1);
      sticky(term("fail_sticky", 3'd3, 31'd3, 32'd5, 32'd3));
      step(32'h1c, 1'b1, 1'b0, '0, '0);
      drained("fail");

      // pc=0 from the first RUN cycle: compares equal to the reset value, halts after 4 equal cycles
      start_run();
      done_q.push_back(term("halt_zero", 3'd4, '0, 32'd4, 32'd0));
      repeat (6) step('0, 1'b0, 1'b0, '0, '0);
      drained("halt_zero");

      // three equal cycles then a change must not halt; 0x40 halts on its fourth equal cycle (cycle 10)
      start_run();
      done_q.push_back(term("halt", 3'd4, '0, 32'd10, 32'd10));
      repeat (4) step(32'h10, 1'b1, 1'b0, '0, '0);
      step(32'h20, 1'b1, 1'b0, '0, '0);
      repeat (7) step(32'h40, 1'b1, 1'b0, '0, '0);
      drained("halt");

      // timeout after 50 RUN cycles
      start_run();
      done_q.push_back(term("timeout", 3'd5, '0, 32'd50, 32'd50));
      for (int k = 1; k <= 53; k++) step(32'(4 * k), 1'b1, 1'b0, '0, '0);
      drained("timeout");

      // cycle 50 has tohost pass, halt and timeout together: pass wins
      start_run();
      done_q.push_back(term("prio", 3'd2, '0, 32'd50, 32'd0));
      for (int k = 1; k <= 45; k++) step(32'(4 * k), 1'b0, 1'b0, '0, '0);
      repeat (4) step(32'h200, 1'b0, 1'b0, '0, '0);
      step(32'h200, 1'b0, 1'b1, 32'h100, 32'd1);
      repeat (2) step(32'h200, 1'b0, 1'b0, '0, '0);
      drained("prio");

      // reset asserted mid-cycle 10 clears outputs without a clock edge
      start_run();
      for (int k = 1; k <= 9; k++) step(32'(4 * k), 1'b1, 1'b0, '0, '0);
      snap_q.push_back(mk(cyc, "pre_rst", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 32'd9, 32'd9));
      bus.pc = 32'h28;
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      cmp(mk(0, "async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0));
      do_reset();
      repeat (5) step(32'h4, 1'b1, 1'b0, '0, '0);
      snap_q.push_back(mk(cyc, "rerun", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 32'd2, 32'd2));
      step(32'h8, 1'b0, 1'b0, '0, '0);
      drained("mid_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
